t2mi_frame_scheduler: RTL and testbench

//  Sequences T2-MI packet generation per T2 frame. Issues BB-frame, timestamp and L1-current packet

---
 rtl/t2mi_pkg.sv | 30 +++
 rtl/t2mi_wait_timer.sv | 26 ++
 rtl/t2mi_frame_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_t2mi_frame_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t2mi_pkg.sv
// T2-MI frame scheduler shared definitions.
// Packet type codes, timestamp modes and FSM state encoding.
package t2mi_pkg;

  localparam logic [7:0] PKT_TYPE_BB    = 8'h00;
  localparam logic [7:0] PKT_TYPE_L1CUR = 8'h10;
  localparam logic [7:0] PKT_TYPE_TS    = 8'h20;

  localparam logic [1:0] TS_TYPE_NONE = 2'd0;
  localparam logic [1:0] TS_TYPE_REL  = 2'd1;
  localparam logic [1:0] TS_TYPE_ABS  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LATCH     = 4'd1,
    S_BB_REQ    = 4'd2,
    S_BB_WAIT   = 4'd3,
    S_TS_REQ    = 4'd4,
    S_TS_WAIT   = 4'd5,
    S_L1_REQ    = 4'd6,
    S_L1_WAIT   = 4'd7,
    S_FRAME_END = 4'd8
  } state_t;

  // Mode 3 is reserved and behaves like "none".
  function automatic logic ts_enabled(input logic [1:0] t);
    return (t == TS_TYPE_REL) || (t == TS_TYPE_ABS);
  endfunction

endpackage

// File: rtl/t2mi_wait_timer.sv
// Loadable 16-bit down-counter guarding the packet-done wait.
// Expires while enabled once the count has reached zero.
module t2mi_wait_timer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_en,
  input  logic [15:0] i_val,
  output logic        o_expired
);

  logic [15:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_en && r_cnt != '0) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  assign o_expired = i_en && (r_cnt == '0);

endmodule

// File: rtl/t2mi_frame_scheduler.sv
// T2-MI per-frame packet sequencer: BB frames, timestamp, L1-current.
// Tracks packet_count and frame/superframe indices for the builder.
module t2mi_frame_scheduler
  import t2mi_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 65535
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic [9:0] plp_num_blocks,
  input  logic [7:0] num_t2_frames,
  input  logic [1:0] timestamp_type,
  input  logic       BB_AVAIL,
  input  logic       PKT_DONE,
  output logic       PKT_START,
  output logic [7:0] PKT_TYPE,
  output logic [7:0] PKT_COUNT,
  output logic [7:0] FRAME_IDX,
  output logic [3:0] SUPERFRAME_IDX,
  output logic       FRAME_START,
  output logic       BUSY,
  output logic       TIMEOUT_ERR,
  output logic       PROTO_ERR
);

  localparam logic [15:0] LOAD_VAL = 16'(WAIT_TIMEOUT - 1);

  state_t     r_state;
  logic [9:0] r_blocks;
  logic [7:0] r_frames;
  logic [1:0] r_ts;
  logic [9:0] r_bb_cnt;
  logic [7:0] r_pkt_cnt;
  logic [7:0] r_frame;
  logic [3:0] r_sf;
  logic       r_first;
  logic       r_start;
  logic [7:0] r_type;
  logic [7:0] r_cnt_o;
  logic [7:0] r_fidx_o;
  logic [3:0] r_sf_o;
  logic       r_fstart;
  logic       r_busy;
  logic       r_tmo;
  logic       r_proto;

  logic       w_issue;
  logic [7:0] w_type;
  logic       w_in_wait;
  logic       w_expired;
  logic       w_bb_more;
  logic [8:0] w_frame_inc;
  logic       w_frame_wrap;
  state_t     w_after_bb;
  state_t     w_first_st;

  always_comb begin
    w_issue   = 1'b0;
    w_type    = PKT_TYPE_BB;
    w_in_wait = 1'b0;
    case (r_state)
      S_BB_REQ: w_issue = BB_AVAIL;
      S_TS_REQ: begin
        w_issue = 1'b1;
        w_type  = PKT_TYPE_TS;
      end
      S_L1_REQ: begin
        w_issue = 1'b1;
        w_type  = PKT_TYPE_L1CUR;
      end
      S_BB_WAIT, S_TS_WAIT, S_L1_WAIT: w_in_wait = 1'b1;
      default: ;
    endcase
  end

  assign w_bb_more    = ({1'b0, r_bb_cnt} + 11'd1) < {1'b0, r_blocks};
  assign w_frame_inc  = {1'b0, r_frame} + 9'd1;
  assign w_frame_wrap = w_frame_inc == {1'b0, r_frames};
  assign w_after_bb   = ts_enabled(r_ts) ? S_TS_REQ : S_L1_REQ;
  assign w_first_st   = (plp_num_blocks != '0) ? S_BB_REQ :
                        ts_enabled(timestamp_type) ? S_TS_REQ : S_L1_REQ;

  t2mi_wait_timer u_timer (
    .i_clk     (CLK),
    .i_rst_n   (RST),
    .i_load    (w_issue),
    .i_en      (w_in_wait),
    .i_val     (LOAD_VAL),
    .o_expired (w_expired)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_blocks  <= '0;
      r_frames  <= '0;
      r_ts      <= '0;
      r_bb_cnt  <= '0;
      r_pkt_cnt <= '0;
      r_frame   <= '0;
      r_sf      <= '0;
      r_first   <= 1'b0;
      r_start   <= 1'b0;
      r_type    <= '0;
      r_cnt_o   <= '0;
      r_fidx_o  <= '0;
      r_sf_o    <= '0;
      r_fstart  <= 1'b0;
      r_busy    <= 1'b0;
      r_tmo     <= 1'b0;
      r_proto   <= 1'b0;
    end else begin
      r_start  <= 1'b0;
      r_fstart <= 1'b0;
      if (PKT_DONE && !w_in_wait) r_proto <= 1'b1;
      if (PKT_DONE && w_in_wait) r_pkt_cnt <= r_pkt_cnt + 8'd1;
      // Indices shown to the builder are frozen at each packet start.
      if (w_issue) begin
        r_start  <= 1'b1;
        r_type   <= w_type;
        r_cnt_o  <= r_pkt_cnt;
        r_fidx_o <= r_frame;
        r_sf_o   <= r_sf;
        r_fstart <= r_first;
        r_first  <= 1'b0;
      end
      case (r_state)
        S_IDLE: if (ENABLE) begin
          r_state <= S_LATCH;
          r_busy  <= 1'b1;
        end
        S_LATCH: begin
          r_blocks <= plp_num_blocks;
          r_frames <= (num_t2_frames == '0) ? 8'd1 : num_t2_frames;
          r_ts     <= timestamp_type;
          r_first  <= 1'b1;
          r_state  <= w_first_st;
        end
        S_BB_REQ: if (w_issue) r_state <= S_BB_WAIT;
        S_TS_REQ: r_state <= S_TS_WAIT;
        S_L1_REQ: r_state <= S_L1_WAIT;
        S_BB_WAIT, S_TS_WAIT, S_L1_WAIT: begin
          if (PKT_DONE) begin
            if (r_state == S_BB_WAIT) begin
              r_bb_cnt <= r_bb_cnt + 10'd1;
              r_state  <= w_bb_more ? S_BB_REQ : w_after_bb;
            end else if (r_state == S_TS_WAIT) begin
              r_state <= S_L1_REQ;
            end else begin
              r_state <= S_FRAME_END;
            end
          end else if (w_expired) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_tmo    <= 1'b1;
            r_bb_cnt <= '0;
          end
        end
        S_FRAME_END: begin
          r_bb_cnt <= '0;
          if (w_frame_wrap) begin
            r_frame <= '0;
            r_sf    <= r_sf + 4'd1;
          end else begin
            r_frame <= w_frame_inc[7:0];
          end
          r_state <= ENABLE ? S_LATCH : S_IDLE;
          r_busy  <= ENABLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign PKT_START      = r_start;
  assign PKT_TYPE       = r_type;
  assign PKT_COUNT      = r_cnt_o;
  assign FRAME_IDX      = r_fidx_o;
  assign SUPERFRAME_IDX = r_sf_o;
  assign FRAME_START    = r_fstart;
  assign BUSY           = r_busy;
  assign TIMEOUT_ERR    = r_tmo;
  assign PROTO_ERR      = r_proto;

endmodule

// File: tb/tb_t2mi_frame_scheduler.sv
// Bench for t2mi_frame_scheduler: directed steps plus randomized frames
// checked against a packet-sequence model built from the frame rules.
module tb_t2mi_frame_scheduler;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       ENABLE = 1'b0;
  logic [9:0] plp_num_blocks = '0;
  logic [7:0] num_t2_frames = '0;
  logic [1:0] timestamp_type = '0;
  logic       BB_AVAIL = 1'b0;
  logic       PKT_DONE = 1'b0;
  logic       PKT_START;
  logic [7:0] PKT_TYPE;
  logic [7:0] PKT_COUNT;
  logic [7:0] FRAME_IDX;
  logic [3:0] SUPERFRAME_IDX;
  logic       FRAME_START;
  logic       BUSY;
  logic       TIMEOUT_ERR;
  logic       PROTO_ERR;

  int n_chk = 0;
  int n_err = 0;
  int m_pkt = 0;
  int m_frame = 0;
  int m_sf = 0;

  t2mi_frame_scheduler #(.WAIT_TIMEOUT(16)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .ENABLE         (ENABLE),
    .plp_num_blocks (plp_num_blocks),
    .num_t2_frames  (num_t2_frames),
    .timestamp_type (timestamp_type),
    .BB_AVAIL       (BB_AVAIL),
    .PKT_DONE       (PKT_DONE),
    .PKT_START      (PKT_START),
    .PKT_TYPE       (PKT_TYPE),
    .PKT_COUNT      (PKT_COUNT),
    .FRAME_IDX      (FRAME_IDX),
    .SUPERFRAME_IDX (SUPERFRAME_IDX),
    .FRAME_START    (FRAME_START),
    .BUSY           (BUSY),
    .TIMEOUT_ERR    (TIMEOUT_ERR),
    .PROTO_ERR      (PROTO_ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] all_out();
    return 64'({PKT_START, PKT_TYPE, PKT_COUNT, FRAME_IDX, SUPERFRAME_IDX,
                FRAME_START, BUSY, TIMEOUT_ERR, PROTO_ERR});
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int b, input int f, input int t);
    plp_num_blocks = 10'(b);
    num_t2_frames  = 8'(f);
    timestamp_type = 2'(t);
  endtask

  // Model: frame index wraps at the effective frame count (0 means 1).
  task automatic frame_end(input int frames);
    int eff;
    int nxt;
    eff = (frames == 0) ? 1 : frames;
    nxt = m_frame + 1;
    if (nxt == eff) begin
      m_frame = 0;
      m_sf = (m_sf + 1) % 16;
    end else begin
      m_frame = nxt % 256;
    end
  endtask

  task automatic expect_pkt(input logic [7:0] typ, input bit first,
                            input int d, input bit drop, input bit rnd_av,
                            output int waited);
    bit seen;
    seen = 1'b0;
    waited = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge CLK);
      if (PKT_START === 1'b1) begin
        seen = 1'b1;
        waited = i;
        break;
      end
      if (rnd_av) BB_AVAIL = 1'($urandom_range(0, 1));
    end
    chk("start_seen", 64'(seen), 64'd1);
    if (!seen) return;
    chk("pkt_type", 64'(PKT_TYPE), 64'(typ));
    chk("pkt_count", 64'(PKT_COUNT), 64'(m_pkt));
    chk("frame_idx", 64'(FRAME_IDX), 64'(m_frame));
    chk("sf_idx", 64'(SUPERFRAME_IDX), 64'(m_sf));
    chk("frame_start", 64'(FRAME_START), 64'(first));
    if (drop) ENABLE = 1'b0;
    if (d >= 0) begin
      repeat (d) @(negedge CLK);
      PKT_DONE = 1'b1;
      @(negedge CLK);
      PKT_DONE = 1'b0;
      m_pkt = (m_pkt + 1) % 256;
    end
  endtask

  // drop_at: packet index at whose start ENABLE falls; >= count means last.
  task automatic do_frame(input int b, input int f, input int t,
                          input bit rnd, input int drop_at);
    int n;
    int idx;
    int w;
    int da;
    bit ts_on;
    ts_on = (t == 1) || (t == 2);
    n = b + (ts_on ? 1 : 0) + 1;
    da = (drop_at >= n) ? n - 1 : drop_at;
    idx = 0;
    for (int k = 0; k < b; k++) begin
      expect_pkt(8'h00, idx == 0, rnd ? int'($urandom_range(0, 4)) : 3,
                 idx == da, rnd, w);
      idx++;
    end
    if (ts_on) begin
      expect_pkt(8'h20, idx == 0, rnd ? int'($urandom_range(0, 4)) : 3,
                 idx == da, rnd, w);
      idx++;
    end
    expect_pkt(8'h10, idx == 0, rnd ? int'($urandom_range(0, 4)) : 3,
               idx == da, rnd, w);
    frame_end(f);
  endtask

  task automatic chk_idle();
    bit any;
    any = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      if (PKT_START === 1'b1) any = 1'b1;
    end
    chk("idle_no_start", 64'(any), 64'd0);
    chk("idle_busy", 64'(BUSY), 64'd0);
  endtask

  initial begin
    int w;
    int nf;
    bit bad;
    repeat (2) @(negedge CLK);
    chk("reset_outputs", all_out(), 64'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk("reset_busy", 64'(BUSY), 64'd0);

    // Three BB, timestamp, L1 per frame; ENABLE drops in frame 3.
    cfg(3, 2, 1);
    BB_AVAIL = 1'b1;
    ENABLE = 1'b1;
    do_frame(3, 2, 1, 1'b0, -1);
    do_frame(3, 2, 1, 1'b0, -1);
    do_frame(3, 2, 1, 1'b0, 1);
    chk_idle();

    // L1-only frames, frame index wrap, and frames=0 acting as 1.
    cfg(0, 3, 0);
    ENABLE = 1'b1;
    for (int f = 0; f < 4; f++) do_frame(0, 3, 0, 1'b1, (f == 3) ? 99 : -1);
    BB_AVAIL = 1'b1;
    chk_idle();
    cfg(0, 0, 3);
    ENABLE = 1'b1;
    for (int f = 0; f < 3; f++) do_frame(0, 0, 3, 1'b1, (f == 2) ? 99 : -1);
    BB_AVAIL = 1'b1;
    chk_idle();

    // BB underrun: long stall without start or timeout.
    cfg(2, 2, 0);
    BB_AVAIL = 1'b0;
    ENABLE = 1'b1;
    bad = 1'b0;
    repeat (1000) begin
      @(negedge CLK);
      if (PKT_START === 1'b1 || TIMEOUT_ERR === 1'b1) bad = 1'b1;
    end
    chk("underrun_quiet", 64'(bad), 64'd0);
    chk("underrun_busy", 64'(BUSY), 64'd1);
    BB_AVAIL = 1'b1;
    expect_pkt(8'h00, 1'b1, 2, 1'b0, 1'b0, w);
    chk("avail_latency", 64'(w), 64'd1);
    expect_pkt(8'h00, 1'b0, 2, 1'b0, 1'b0, w);
    expect_pkt(8'h10, 1'b0, 2, 1'b1, 1'b0, w);
    frame_end(2);
    chk_idle();

    // Withheld PKT_DONE: abort after 16 wait cycles.
    cfg(1, 2, 0);
    ENABLE = 1'b1;
    expect_pkt(8'h00, 1'b1, -1, 1'b1, 1'b0, w);
    nf = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (TIMEOUT_ERR === 1'b1) begin
        nf = i;
        break;
      end
    end
    chk("timeout_cycles", 64'(nf), 64'd16);
    chk("timeout_busy", 64'(BUSY), 64'd0);
    chk("timeout_fidx", 64'(FRAME_IDX), 64'(m_frame));
    chk("proto_clean", 64'(PROTO_ERR), 64'd0);

    // Spurious PKT_DONE while idle, then a frame with mid-frame ENABLE drop.
    @(negedge CLK);
    PKT_DONE = 1'b1;
    @(negedge CLK);
    PKT_DONE = 1'b0;
    @(negedge CLK);
    chk("proto_err", 64'(PROTO_ERR), 64'd1);
    chk("proto_busy", 64'(BUSY), 64'd0);
    cfg(2, 1, 2);
    ENABLE = 1'b1;
    do_frame(2, 1, 2, 1'b0, 1);
    chk_idle();
    chk("timeout_sticky", 64'(TIMEOUT_ERR), 64'd1);

    // Randomized configurations and handshake delays.
    for (int k = 0; k < 6; k++) begin
      int b;
      int f;
      int t;
      int n;
      b = int'($urandom_range(0, 4));
      f = int'($urandom_range(0, 3));
      t = int'($urandom_range(0, 3));
      n = int'($urandom_range(1, 3));
      cfg(b, f, t);
      ENABLE = 1'b1;
      for (int j = 0; j < n; j++) do_frame(b, f, t, 1'b1, (j == n - 1) ? 99 : -1);
      BB_AVAIL = 1'b1;
      chk_idle();
    end

    // Config change mid-frame applies to the next frame only.
    cfg(3, 2, 0);
    ENABLE = 1'b1;
    expect_pkt(8'h00, 1'b1, 2, 1'b0, 1'b0, w);
    plp_num_blocks = 10'd5;
    expect_pkt(8'h00, 1'b0, 2, 1'b0, 1'b0, w);
    expect_pkt(8'h00, 1'b0, 2, 1'b0, 1'b0, w);
    expect_pkt(8'h10, 1'b0, 2, 1'b0, 1'b0, w);
    frame_end(2);
    for (int k = 0; k < 4; k++) expect_pkt(8'h00, k == 0, 1, 1'b0, 1'b0, w);
    expect_pkt(8'h00, 1'b0, -1, 1'b0, 1'b0, w);
    chk("pre_reset_busy", 64'(BUSY), 64'd1);

    // Asynchronous reset in the middle of a packet.
    #2;
    RST = 1'b0;
    #1;
    chk("async_reset", all_out(), 64'd0);
    ENABLE = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    m_pkt = 0;
    m_frame = 0;
    m_sf = 0;
    cfg(1, 1, 1);
    ENABLE = 1'b1;
    do_frame(1, 1, 1, 1'b0, 99);
    chk_idle();
    chk("post_reset_tmo", 64'(TIMEOUT_ERR), 64'd0);
    chk("post_reset_proto", 64'(PROTO_ERR), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
